// File: rtl/seg7_display_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller: display
// modes, the blank pattern and the active-low gfedcba code for each hex value.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic {
    DISP_STATIC = 1'b0,
    DISP_SCROLL = 1'b1
  } disp_mode_t;

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Bundle of control/data signals between the lock FSM (master) and the
// display controller (slave); hex carries the active-low segment pins.
interface seg7_display_ctrl_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6
);

  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic                      lz_blank;
  disp_mode_t                mode;
  logic [7*NUM_DIGITS-1:0]   hex;

  modport master (
    output enable, load, digits, blank_mask, blink_mask, lz_blank, mode,
    input  hex
  );

  modport slave (
    input  enable, load, digits, blank_mask, blink_mask, lz_blank, mode,
    output hex
  );

endinterface

// File: rtl/seg7_display_ctrl_hex_to_seg7.sv
// Pure combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Map each nibble value onto its segment pattern
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// N-digit seven-segment controller: shadow register for the digit word,
// blink and scroll timers, rotation, masking and registered active-low output.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCROLL_DIV = 12_500_000
) (
  input logic               clk,
  input logic               rst,
  seg7_display_ctrl_if.slave bus
);

  localparam int BLINK_W  = $clog2(BLINK_DIV);
  localparam int SCROLL_W = $clog2(SCROLL_DIV);
  localparam int OFFSET_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [BLINK_W-1:0]      r_blinkCnt;
  logic                    r_blinkPhase;
  logic [SCROLL_W-1:0]     r_scrollCnt;
  logic [OFFSET_W-1:0]     r_offset;
  logic [7*NUM_DIGITS-1:0] r_hex;

  disp_mode_t              w_mode;
  logic                    w_blinkWrap;
  logic                    w_scrollWrap;
  logic                    w_lzActive;
  logic [OFFSET_W-1:0]     w_effOffset;
  logic [4*NUM_DIGITS-1:0] w_rotDigits;
  logic [NUM_DIGITS-1:0]   w_lzBlank;
  logic [7*NUM_DIGITS-1:0] w_decoded;
  logic [7*NUM_DIGITS-1:0] w_nextHex;

  assign w_mode       = bus.mode;
  assign w_blinkWrap  = (r_blinkCnt == BLINK_W'(BLINK_DIV - 1));
  assign w_scrollWrap = (r_scrollCnt == SCROLL_W'(SCROLL_DIV - 1));
  assign w_lzActive   = bus.lz_blank && (w_mode == DISP_STATIC);
  // Static mode always displays unrotated, even on the edge that clears the offset
  assign w_effOffset  = (w_mode == DISP_SCROLL) ? r_offset : '0;
  assign bus.hex      = r_hex;

  // Shadow copy of the digit word, captured only on an enabled load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (bus.enable && bus.load) begin
      r_shadow <= bus.digits;
    end else begin
      r_shadow <= r_shadow;
    end
  end

  // Blink timer: phase toggles every BLINK_DIV enabled cycles, restarted by load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (!bus.enable) begin
      r_blinkCnt   <= r_blinkCnt;
      r_blinkPhase <= r_blinkPhase;
    end else if (bus.load) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (w_blinkWrap) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= ~r_blinkPhase;
    end else begin
      r_blinkCnt   <= r_blinkCnt + BLINK_W'(1);
      r_blinkPhase <= r_blinkPhase;
    end
  end

  // Scroll timer: advances the rotation offset every SCROLL_DIV cycles in scroll mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scrollCnt <= '0;
      r_offset    <= '0;
    end else if (!bus.enable) begin
      r_scrollCnt <= r_scrollCnt;
      r_offset    <= r_offset;
    end else if (bus.load || (w_mode == DISP_STATIC)) begin
      r_scrollCnt <= '0;
      r_offset    <= '0;
    end else if (w_scrollWrap) begin
      r_scrollCnt <= '0;
      r_offset    <= (r_offset == OFFSET_W'(NUM_DIGITS - 1)) ? '0 : r_offset + OFFSET_W'(1);
    end else begin
      r_scrollCnt <= r_scrollCnt + SCROLL_W'(1);
      r_offset    <= r_offset;
    end
  end

  // Left rotation: position p shows shadow digit (p - offset) mod NUM_DIGITS
  always_comb begin
    int src;
    src = 0;
    w_rotDigits = '0;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      src = p - int'(w_effOffset);
      if (src < 0) src = src + NUM_DIGITS;
      w_rotDigits[4*p +: 4] = r_shadow[4*src +: 4];
    end
  end

  // Leading-zero map: blank from the top down until the first nonzero digit, never digit 0
  always_comb begin
    logic seenNonzero;
    seenNonzero = 1'b0;
    w_lzBlank = '0;
    for (int p = NUM_DIGITS - 1; p >= 1; p--) begin
      if (r_shadow[4*p +: 4] != 4'h0) seenNonzero = 1'b1;
      w_lzBlank[p] = ~seenNonzero;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
      hex_to_seg7 u_dec (
        .i_digit (w_rotDigits[4*g +: 4]),
        .o_seg   (w_decoded[7*g +: 7])
      );
    end
  endgenerate

  // Per-position priority: forced blank, then blink-off phase, then leading zero, then decode
  always_comb begin
    w_nextHex = '0;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      if (bus.blank_mask[p]) begin
        w_nextHex[7*p +: 7] = SEG_BLANK;
      end else if (r_blinkPhase && bus.blink_mask[p]) begin
        w_nextHex[7*p +: 7] = SEG_BLANK;
      end else if (w_lzActive && w_lzBlank[p]) begin
        w_nextHex[7*p +: 7] = SEG_BLANK;
      end else begin
        w_nextHex[7*p +: 7] = w_decoded[7*p +: 7];
      end
    end
  end

  // Registered segment outputs, all dark while in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex <= {NUM_DIGITS{SEG_BLANK}};
    end else if (bus.enable) begin
      r_hex <= w_nextHex;
    end else begin
      r_hex <= r_hex;
    end
  end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
Parametrised N-digit 7-segment display controller and the successor of the fixed six-digit decoder. Captures a packed hex-digit word into a shadow register and drives registered, active-low segment outputs. Adds per-digit blanking, timed blinking, leading-zero suppression and a rotating scroll mode. Sits between the lock FSM and the board HEX pins.

Parameters:
NUM_DIGITS, 6, number of digits/displays (2..8)
BLINK_DIV, 25_000_000, clock cycles per blink half-period (>=2)
SCROLL_DIV, 12_500_000, clock cycles per scroll step (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  1 = block active; 0 = outputs, shadow and counters frozen
load  in  1  capture digits into shadow (qualified by enable)
digits  in  4*NUM_DIGITS  packed hex digits; digit i = [4i+3:4i], digit 0 rightmost
blank_mask  in  NUM_DIGITS  1 = digit i forced blank
blink_mask  in  NUM_DIGITS  1 = digit i blinks
lz_blank  in  1  1 = suppress leading zeros (static mode only)
mode  in  1  0 = STATIC, 1 = SCROLL
hex  out  7*NUM_DIGITS  segments, digit i = [7i+6:7i], bit order gfedcba, active-low

Behaviour:
- Reset (async, rst=1): shadow=0, blink_cnt=0, blink_phase=0, scroll_cnt=0, offset=0, hex = all 1s (every digit 7'b1111111).
- Decode (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110; blank=1111111.
- enable=0: all state and hex hold exactly; load ignored; no latches (every register has explicit hold).
- load & enable: shadow<=digits; blink_cnt, blink_phase, scroll_cnt, offset <=0 in the same edge. hex reflects new shadow one cycle later (registered output, latency 1).
- Blink: while enabled, blink_cnt counts 0..BLINK_DIV-1; on wrap blink_phase toggles. Phase 1 blanks digits with blink_mask=1; phase 0 shows them.
- Scroll: mode=1 and enabled: scroll_cnt counts 0..SCROLL_DIV-1; on wrap offset <= (offset==NUM_DIGITS-1) ? 0 : offset+1. Position i shows shadow digit (i - offset) mod NUM_DIGITS (left rotate). mode=0: offset and scroll_cnt held at 0 (cleared on the edge mode is sampled 0).
- Leading-zero blank: mode=0 and lz_blank=1: from digit NUM_DIGITS-1 downward, zero digits blank until the first nonzero; digit 0 never blanked (all-zero shows "0"). Ignored in scroll mode.
- Priority per position: blank_mask > blink (phase 1) > leading-zero > decode. Masks apply to output position i, not source digit.
- Mask/mode/lz inputs act without load; effect visible on hex one cycle after sampling.
- rst mid-scroll or mid-blink: immediate all-blank; after release, shadow=0 so outputs show decoded zeros one cycle after first enabled edge.

Decomposition:
- Package seg7_pkg: SEG_BLANK = 7'b1111111, mode enum disp_mode_t {DISP_STATIC, DISP_SCROLL}, segment code constants 0..F.
- Sub-module hex_to_seg7 (pure combinational 4->7 decoder), instantiated NUM_DIGITS times; counters, shadow, rotation and masking in seg7_display_ctrl.

Test Plan:
- Reset then enable=1, no load -> after one edge all digits = 1000000; while rst=1, hex = all 1111111.
- NUM_DIGITS=6, load digits=24'h12AB0F, mode=0 -> hex5..0 = 1111001,0100100,0001000,0000011,1000000,0001110 after 1 cycle.
- load 24'h000705, lz_blank=1 -> hex5..3 blank, hex2=1111000, hex1=1000000, hex0=0010010; load 0 -> only hex0 = 1000000.
- BLINK_DIV=4, blink_mask=6'b000001, shadow=24'h123456 -> hex0 alternates 0000010 / 1111111 every 4 cycles; other digits steady; load mid-period restarts phase 0.
- SCROLL_DIV=3, mode=1, shadow=24'h123456 -> after 3 cycles hex5..0 reads 2,3,4,5,6,1; after 18 cycles back to 1..6; enable=0 mid-run freezes hex and counters.
- rst asserted during scroll at offset=2 -> hex all 1111111 asynchronously; after release offset=0, shadow=0.
